exp_3x3_ker_write_cont: RTL and testbench
=========================================

# exp_3x3_ker_write_cont

Write-side controller for the expand 3x3 kernel RAM. It accepts kernel words from the upstream kernel stream and writes them into a two-bank ping-pong RAM: bank 1 at addresses 0-63, bank 2 at 64-127. It raises `layer_1_ready_o` / `layer_2_ready_o` when a bank is full and frees the bank on `layer_1_done_i` / `layer_2_done_i` from the 3x3 kernel read controller. It sits directly upstream of that read controller and drives its layer handshake.

## Interface
- `DATA_WIDTH`, 72: width of one kernel RAM word.
- `clk_i` input 1: system clock, rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `start_i` input 1: synchronous one-cycle pulse; aborts any load, latches config, begins a new fire load.
- `one_exp3_ker_addr_limit_i` input 7: words per bank fill. Legal 1..64; 0 is treated as 1; values above 64 as 64. Latched on `start_i`.
- `exp3_ker_chunks_i` input 10: number of bank fills in this fire, minus 1. Latched on `start_i`.
- `ker_data_i` input DATA_WIDTH: incoming kernel word.
- `ker_valid_i` input 1: `ker_data_i` valid.
- `ker_ready_o` output 1: controller can accept a word this cycle.
- `exp_3x3_ram_wr_en_o` output 1: RAM write strobe.
- `exp_3x3_ram_wr_addr_o` output 7: RAM write address.
- `exp_3x3_ram_wr_data_o` output DATA_WIDTH: RAM write data.
- `layer_1_ready_o` output 1: bank 1 (0-63) holds a complete fill.
- `layer_1_done_i` input 1: one-cycle pulse; reader has finished bank 1.
- `layer_2_ready_o` output 1: bank 2 (64-127) holds a complete fill.
- `layer_2_done_i` input 1: one-cycle pulse; reader has finished bank 2.
- `load_done_o` output 1: one-cycle pulse when the last fill of the fire becomes ready.

## Operation
- Reset values: all outputs 0; FSM in IDLE; word counter, chunk counter and bank select all 0.
- FSM states:
  - IDLE to WAIT_BANK on `start_i`.
  - WAIT_BANK to FILL when the target bank is free, i.e. its ready flag is 0.
  - FILL to WAIT_BANK after the last word of a fill, if more chunks remain.
  - FILL to IDLE after the last word of the final chunk.
- Target bank starts at bank 1 and toggles after each completed fill.
- `ker_ready_o` = (state == FILL). This is registered-state based, with no combinational path from `ker_valid_i`.
- A word is accepted when `ker_valid_i && ker_ready_o`.
- On each accept:
  - write address is the bank base (0 or 64) plus the word counter;
  - the word counter increments, 6 bits, 0..L-1.
- On the accept of word L-1:
  - the word counter clears;
  - the chunk counter increments;
  - `ker_ready_o` falls the next cycle.
- Bank flags:
  - set one cycle after the final `exp_3x3_ram_wr_en_o` of that fill;
  - cleared the cycle after the matching done pulse;
  - a done pulse for a bank whose ready flag is 0 is ignored.
- Fill and done on opposite banks in the same cycle are independent. Filling bank 2 while bank 1 is being read is the normal overlap.
- When both banks are ready, the FSM holds in WAIT_BANK and `ker_ready_o` stays 0 (backpressure).
- `start_i` mid-operation, same cycle:
  - clears both ready flags and all counters;
  - drops `ker_ready_o` and any pending write;
  - the next fill targets bank 1.
- `rst_i` mid-operation: all state clears asynchronously; no RAM write is issued after reset assertion.
- Chunk counter is 10 bits and compares equal to the latched `exp3_ker_chunks_i`. No wrap within a fire.

## Timing
- Accept at cycle N: `exp_3x3_ram_wr_en_o`, address and data are registered and valid at cycle N+1.
- Last write at N+1: bank ready flag is 1 at N+2.
- `load_done_o` pulses at N+2 for the final chunk only.
- WAIT_BANK to FILL: one cycle after the target flag is seen 0. The earliest `ker_ready_o` is two cycles after the done pulse.
- `start_i` at cycle S: `ker_ready_o` is 0 at S+1. FILL (bank 1 free after clear) begins at S+2.
- Throughput: one word per cycle during FILL.

## Test plan
- Basic fill:
  - stimulus: L=4, chunks=0, valid held high, start;
  - response: writes at addresses 0,1,2,3 on consecutive cycles; `layer_1_ready_o` = 1 the cycle after address 3; `load_done_o` pulses once; FSM returns to IDLE.
- Ping-pong:
  - stimulus: L=64, chunks=2, no done pulses;
  - response: bank 1 written at 0-63; bank 2 written at 64-127; `ker_ready_o` then stays 0.
  - stimulus: `layer_1_done_i` pulse;
  - response: third fill writes 0-63 and `load_done_o` pulses.
- Valid gaps:
  - stimulus: L=8, `ker_valid_i` toggling every cycle;
  - response: exactly 8 writes, contiguous addresses 0-7, data matches the accepted order.
- Spurious and simultaneous handshakes:
  - spurious `layer_2_done_i` with bank 2 not ready: no flag change;
  - done for bank 1 in the same cycle as the last write of bank 2: bank 1 clears and bank 2 sets on the next cycle.
- Abort and reset:
  - `start_i` during the fill of bank 2, word 10: both flags 0; next writes begin at address 0.
  - `rst_i` asserted mid-fill: all outputs 0 immediately, asynchronously.
- Config clamping:
  - limit 0: fills are one word (address 0, then 64);
  - limit 100: fills are 64 words.

Source files
------------

// File: rtl/exp_3x3_ker_write_cont_if.sv
// Kernel stream, kernel RAM write port and layer handshake of the expand 3x3
// kernel write controller, bundled as one interface.
interface exp_3x3_ker_write_cont_if #(
    parameter int unsigned DATA_WIDTH = 72
) ();

    // Upstream kernel stream
    logic [DATA_WIDTH-1:0] ker_data;
    logic                  ker_valid;
    logic                  ker_ready;

    // Kernel RAM write port
    logic                  ram_wr_en;
    logic [6:0]            ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;

    // Layer handshake with the 3x3 kernel read controller
    logic                  layer_1_ready;
    logic                  layer_1_done;
    logic                  layer_2_ready;
    logic                  layer_2_done;
    logic                  load_done;

    modport master (
        input  ker_data,
        input  ker_valid,
        output ker_ready,
        output ram_wr_en,
        output ram_wr_addr,
        output ram_wr_data,
        output layer_1_ready,
        input  layer_1_done,
        output layer_2_ready,
        input  layer_2_done,
        output load_done
    );

    modport slave (
        output ker_data,
        output ker_valid,
        input  ker_ready,
        input  ram_wr_en,
        input  ram_wr_addr,
        input  ram_wr_data,
        input  layer_1_ready,
        output layer_1_done,
        input  layer_2_ready,
        output layer_2_done,
        input  load_done
    );

endinterface

// File: rtl/exp_3x3_ker_write_cont.sv
// Write-side controller for the expand 3x3 kernel RAM: streams kernel words into
// a two-bank ping-pong RAM (0-63 / 64-127) and hands full banks to the reader.
module exp_3x3_ker_write_cont #(
    parameter int unsigned DATA_WIDTH = 72
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [6:0] one_exp3_ker_addr_limit_i,
    input  logic [9:0] exp3_ker_chunks_i,
    exp_3x3_ker_write_cont_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitBank,
        StFill
    } state_e;

    state_e                state_q, state_d;
    logic [5:0]            word_cnt_q, word_cnt_d;
    logic [9:0]            chunk_cnt_q, chunk_cnt_d;
    logic                  bank_q, bank_d;
    logic [6:0]            limit_q, limit_d;
    logic [9:0]            chunks_q, chunks_d;
    logic                  l1_rdy_q, l1_rdy_d;
    logic                  l2_rdy_q, l2_rdy_d;
    logic                  fill_end_q, fill_end_d;
    logic                  fill_bank_q, fill_bank_d;
    logic                  fill_last_q, fill_last_d;
    logic                  wr_en_q, wr_en_d;
    logic [6:0]            wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  load_done_q, load_done_d;

    logic [6:0] limit_clamped;
    logic       last_word;
    logic       last_chunk;
    logic       target_busy;

    always_comb begin
        if (one_exp3_ker_addr_limit_i == 7'd0) begin
            limit_clamped = 7'd1;
        end else if (one_exp3_ker_addr_limit_i > 7'd64) begin
            limit_clamped = 7'd64;
        end else begin
            limit_clamped = one_exp3_ker_addr_limit_i;
        end
    end

    assign last_word   = ({1'b0, word_cnt_q} == (limit_q - 7'd1));
    assign last_chunk  = (chunk_cnt_q == chunks_q);
    assign target_busy = bank_q ? l2_rdy_q : l1_rdy_q;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        chunk_cnt_d = chunk_cnt_q;
        bank_d      = bank_q;
        limit_d     = limit_q;
        chunks_d    = chunks_q;
        fill_end_d  = 1'b0;
        fill_bank_d = fill_bank_q;
        fill_last_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        load_done_d = fill_end_q && fill_last_q;

        // A done pulse only clears a flag that is set; a completing fill wins.
        l1_rdy_d = l1_rdy_q && !bus.layer_1_done;
        l2_rdy_d = l2_rdy_q && !bus.layer_2_done;
        if (fill_end_q && !fill_bank_q) l1_rdy_d = 1'b1;
        if (fill_end_q && fill_bank_q)  l2_rdy_d = 1'b1;

        unique case (state_q)
            StIdle: begin
            end
            StWaitBank: begin
                if (!target_busy) state_d = StFill;
            end
            StFill: begin
                if (bus.ker_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {bank_q, word_cnt_q};
                    wr_data_d = bus.ker_data;
                    if (last_word) begin
                        word_cnt_d  = 6'd0;
                        chunk_cnt_d = chunk_cnt_q + 10'd1;
                        bank_d      = ~bank_q;
                        fill_end_d  = 1'b1;
                        fill_bank_d = bank_q;
                        fill_last_d = last_chunk;
                        state_d     = last_chunk ? StIdle : StWaitBank;
                    end else begin
                        word_cnt_d = word_cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Start aborts everything in flight, including a word accepted this cycle.
        if (start_i) begin
            state_d     = StWaitBank;
            word_cnt_d  = 6'd0;
            chunk_cnt_d = 10'd0;
            bank_d      = 1'b0;
            limit_d     = limit_clamped;
            chunks_d    = exp3_ker_chunks_i;
            l1_rdy_d    = 1'b0;
            l2_rdy_d    = 1'b0;
            fill_end_d  = 1'b0;
            fill_last_d = 1'b0;
            wr_en_d     = 1'b0;
            load_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            word_cnt_q  <= 6'd0;
            chunk_cnt_q <= 10'd0;
            bank_q      <= 1'b0;
            limit_q     <= 7'd0;
            chunks_q    <= 10'd0;
            l1_rdy_q    <= 1'b0;
            l2_rdy_q    <= 1'b0;
            fill_end_q  <= 1'b0;
            fill_bank_q <= 1'b0;
            fill_last_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            chunk_cnt_q <= chunk_cnt_d;
            bank_q      <= bank_d;
            limit_q     <= limit_d;
            chunks_q    <= chunks_d;
            l1_rdy_q    <= l1_rdy_d;
            l2_rdy_q    <= l2_rdy_d;
            fill_end_q  <= fill_end_d;
            fill_bank_q <= fill_bank_d;
            fill_last_q <= fill_last_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            load_done_q <= load_done_d;
        end
    end

    assign bus.ker_ready     = (state_q == StFill);
    assign bus.ram_wr_en     = wr_en_q;
    assign bus.ram_wr_addr   = wr_addr_q;
    assign bus.ram_wr_data   = wr_data_q;
    assign bus.layer_1_ready = l1_rdy_q;
    assign bus.layer_2_ready = l2_rdy_q;
    assign bus.load_done     = load_done_q;

endmodule

// File: tb/tb_exp_3x3_ker_write_cont.sv
// Bench for exp_3x3_ker_write_cont: directed handshake scenarios plus random fires,
// all writes and bank flags checked against a word-index reference model.
module tb_exp_3x3_ker_write_cont;

    localparam int unsigned DW = 72;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] lim;
    logic [9:0] chk;

    exp_3x3_ker_write_cont_if #(.DATA_WIDTH(DW)) bus ();

    exp_3x3_ker_write_cont #(.DATA_WIDTH(DW)) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .start_i                  (start),
        .one_exp3_ker_addr_limit_i(lim),
        .exp3_ker_chunks_i        (chk),
        .bus                      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp_lim(input int v);
        if (v == 0) return 1;
        if (v > 64) return 64;
        return v;
    endfunction

    // Stimulus controls: 0 valid low, 1 valid high, 2 toggle, 3 random
    int vmode     = 0;
    bit rand_done = 1'b0;
    bit frc_d1    = 1'b0;
    bit frc_d2    = 1'b0;

    initial begin : driver
        logic [95:0] r;
        bus.ker_valid    = 1'b0;
        bus.ker_data     = '0;
        bus.layer_1_done = 1'b0;
        bus.layer_2_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            r = {$urandom(), $urandom(), $urandom()};
            bus.ker_data = r[DW-1:0];
            case (vmode)
                1:       bus.ker_valid = 1'b1;
                2:       bus.ker_valid = ~bus.ker_valid;
                3:       bus.ker_valid = ($urandom_range(0, 1) == 1);
                default: bus.ker_valid = 1'b0;
            endcase
            bus.layer_1_done = frc_d1 | (rand_done && ($urandom_range(0, 15) == 0));
            bus.layer_2_done = frc_d2 | (rand_done && ($urandom_range(0, 15) == 0));
        end
    end

    // Reference model: word k of a fire lands in fill k/L, bank (k/L)%2, offset k%L.
    int             m_l, m_chunks, m_k;
    bit             m_active;
    bit             f1, f2, p1, p2, ld, pld, we;
    logic [6:0]     wa;
    logic [DW-1:0]  wd;
    int             wr_cnt, ld_cnt;
    logic [6:0]     last_addr;

    always @(negedge clk) begin : monitor
        int fill;
        int w;
        bit nf1;
        bit nf2;
        if (rst) begin
            m_active = 1'b0; m_k = 0; m_l = 1; m_chunks = 0;
            f1 = 0; f2 = 0; p1 = 0; p2 = 0; ld = 0; pld = 0; we = 0;
            wa = '0; wd = '0; wr_cnt = 0; ld_cnt = 0; last_addr = '0;
        end else begin
            check("wr_en", 128'(bus.ram_wr_en), 128'(we));
            if (we) begin
                check("wr_addr", 128'(bus.ram_wr_addr), 128'(wa));
                check("wr_data", 128'(bus.ram_wr_data), 128'(wd));
            end
            check("layer_1_ready", 128'(bus.layer_1_ready), 128'(f1));
            check("layer_2_ready", 128'(bus.layer_2_ready), 128'(f2));
            check("load_done", 128'(bus.load_done), 128'(ld));
            if (!m_active || (f1 && f2)) check("ker_ready_low", 128'(bus.ker_ready), 128'(0));
            if (bus.ram_wr_en) begin
                wr_cnt++;
                last_addr = bus.ram_wr_addr;
            end
            if (bus.load_done) ld_cnt++;

            nf1 = (f1 && !bus.layer_1_done) || p1;
            nf2 = (f2 && !bus.layer_2_done) || p2;
            p1 = 0; p2 = 0; ld = pld; pld = 0; we = 0;
            if (start) begin
                nf1 = 0; nf2 = 0; ld = 0;
                m_l = clamp_lim(int'(lim)); m_chunks = int'(chk);
                m_k = 0; m_active = 1'b1; wr_cnt = 0; ld_cnt = 0;
            end else if (m_active && bus.ker_valid && bus.ker_ready) begin
                fill = m_k / m_l;
                w    = m_k % m_l;
                we   = 1'b1;
                wa   = 7'((fill % 2) * 64 + w);
                wd   = bus.ker_data;
                m_k++;
                if (w == m_l - 1) begin
                    if (fill % 2 == 0) p1 = 1'b1;
                    else               p2 = 1'b1;
                    if (fill == m_chunks) begin
                        pld      = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end
            f1 = nf1;
            f2 = nf2;
        end
    end

    task automatic do_start(input int l, input int c);
        @(posedge clk); #1;
        lim   = 7'(l);
        chk   = 10'(c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_ready_s1", 128'(bus.ker_ready), 128'(0));
        @(negedge clk);
        check("start_ready_s2", 128'(bus.ker_ready), 128'(1));
    endtask

    task automatic wait_fire(input int budget);
        int n = 0;
        while (m_active && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("fire_timeout", 128'(m_active), 128'(0));
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input int b);
        @(posedge clk); #1;
        if (b == 1) frc_d1 = 1'b1;
        else        frc_d2 = 1'b1;
        @(posedge clk); #1;
        frc_d1 = 1'b0;
        frc_d2 = 1'b0;
    endtask

    initial begin : main
        int n;
        int l;
        int c;
        rst = 1'b1; start = 1'b0; lim = '0; chk = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ker_ready", 128'(bus.ker_ready), 128'(0));
        check("rst_wr_en", 128'(bus.ram_wr_en), 128'(0));
        check("rst_wr_addr", 128'(bus.ram_wr_addr), 128'(0));
        check("rst_l1", 128'(bus.layer_1_ready), 128'(0));
        check("rst_l2", 128'(bus.layer_2_ready), 128'(0));
        check("rst_load_done", 128'(bus.load_done), 128'(0));
        rst = 1'b0;

        // Basic fill
        vmode = 1;
        do_start(4, 0);
        wait_fire(100);
        check("basic_writes", 128'(wr_cnt), 128'(4));
        check("basic_last_addr", 128'(last_addr), 128'(3));
        check("basic_load_done", 128'(ld_cnt), 128'(1));
        check("basic_l1", 128'(bus.layer_1_ready), 128'(1));

        // Ping-pong with the reader stalled
        do_start(64, 2);
        n = 0;
        while (wr_cnt < 128 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        check("pp_writes_stall", 128'(wr_cnt), 128'(128));
        check("pp_ready_stall", 128'(bus.ker_ready), 128'(0));
        check("pp_both_full", 128'({bus.layer_1_ready, bus.layer_2_ready}), 128'(3));
        check("pp_no_load_done", 128'(ld_cnt), 128'(0));
        frc_d1 = 1'b1;
        @(posedge clk); #1;
        frc_d1 = 1'b0;
        check("pp_done_d1", 128'(bus.ker_ready), 128'(0));
        @(posedge clk); #1;
        check("pp_done_d2", 128'(bus.ker_ready), 128'(1));
        wait_fire(500);
        check("pp_writes", 128'(wr_cnt), 128'(192));
        check("pp_last_addr", 128'(last_addr), 128'(63));
        check("pp_load_done", 128'(ld_cnt), 128'(1));

        // Valid gaps, then a spurious bank-2 done
        vmode = 2;
        do_start(8, 0);
        wait_fire(200);
        check("gap_writes", 128'(wr_cnt), 128'(8));
        check("gap_last_addr", 128'(last_addr), 128'(7));
        pulse_done(2);
        check("spur_flags", 128'({bus.layer_1_ready, bus.layer_2_ready}), 128'(2));

        // Bank-1 done in the cycle of bank 2's last write
        vmode = 1;
        do_start(4, 1);
        n = 0;
        while (m_k != 8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        frc_d1 = 1'b1;
        @(negedge clk);
        check("sim_last_addr", 128'({bus.ram_wr_en, bus.ram_wr_addr}), 128'({1'b1, 7'd67}));
        check("sim_pre_flags", 128'({bus.layer_1_ready, bus.layer_2_ready}), 128'(2));
        @(posedge clk); #1;
        frc_d1 = 1'b0;
        check("sim_post_flags", 128'({bus.layer_1_ready, bus.layer_2_ready}), 128'(1));
        wait_fire(50);

        // Abort during bank 2, word 10
        do_start(16, 3);
        n = 0;
        while (m_k != 26 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        lim = 7'd16; chk = 10'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_flags", 128'({bus.layer_1_ready, bus.layer_2_ready}), 128'(0));
        check("abort_ready", 128'(bus.ker_ready), 128'(0));
        n = 0;
        while (!bus.ram_wr_en && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_first_addr", 128'({bus.ram_wr_en, bus.ram_wr_addr}), 128'({1'b1, 7'd0}));
        wait_fire(100);
        check("abort_writes", 128'(wr_cnt), 128'(16));

        // Asynchronous reset mid-fill
        do_start(32, 0);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_ker_ready", 128'(bus.ker_ready), 128'(0));
        check("arst_wr", 128'({bus.ram_wr_en, bus.ram_wr_addr}), 128'(0));
        check("arst_wr_data", 128'(bus.ram_wr_data), 128'(0));
        check("arst_flags", 128'({bus.layer_1_ready, bus.layer_2_ready, bus.load_done}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("arst_idle_wr", 128'(bus.ram_wr_en), 128'(0));

        // Limit clamping
        do_start(0, 1);
        wait_fire(50);
        check("clamp0_writes", 128'(wr_cnt), 128'(2));
        check("clamp0_last_addr", 128'(last_addr), 128'(64));
        do_start(100, 0);
        wait_fire(200);
        check("clamp100_writes", 128'(wr_cnt), 128'(64));
        check("clamp100_last_addr", 128'(last_addr), 128'(63));

        // Random fires with random valid and random (some spurious) done pulses
        vmode = 3;
        rand_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            l = (i % 4 == 3) ? int'($urandom_range(65, 127)) : int'($urandom_range(0, 64));
            c = int'($urandom_range(0, 3));
            do_start(l, c);
            wait_fire(8000);
            check("rand_writes", 128'(wr_cnt), 128'(clamp_lim(l) * (c + 1)));
            check("rand_load_done", 128'(ld_cnt), 128'(1));
        end
        rand_done = 1'b0;
        vmode = 0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
